dump_trigger_ctrl: RTL and testbench

- Run-time controller that decides when waveform capture runs and which probe groups are active.
- Counts video frames from vertical sync and arms on a start frame or on the end of ROM download.
- Closes the capture window on a stop frame.
- Sits in the test harness beside the game top; drives per-group dump enables consumed by the simulator dump hooks and by on-chip capture logic.

---
 rtl/dump_trigger_ctrl.sv | 141 ++++++++++++++
 tb/tb_dump_trigger_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dump_trigger_ctrl.sv
// Capture-window controller: counts frames from vertical sync, opens the dump
// window on a start frame / download end / immediately, and closes it on a stop frame.
module dump_trigger_ctrl #(
  parameter int CW   = 32,
  parameter int CH   = 4,
  parameter int SYNC = 1,
  parameter int MINT = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          dwnld,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] start_frame,
  input  logic [CW-1:0] stop_frame,
  input  logic [CH-1:0] ch_mask,
  output logic [CW-1:0] frame_cnt,
  output logic [CH-1:0] dump_en,
  output logic          dump_on,
  output logic          dump_off,
  output logic [1:0]    st
);

  localparam int             MW       = (MINT < 1) ? 1 : $clog2(MINT + 1);
  localparam logic [MW-1:0]  MINT_SAT = MW'(MINT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DUMPING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q;
  logic [CW-1:0] frame_q, frame_d;
  logic [CH-1:0] dump_en_q, dump_en_d;
  logic          dump_on_q, dump_on_d;
  logic          dump_off_q, dump_off_d;
  logic [MW-1:0] mint_q;
  logic          vs_p_q, dl_p_q;
  logic          vs_s, dl_s;

  if (SYNC != 0) begin : g_sync
    logic vs_m_q, vs_s_q, dl_m_q, dl_s_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vs_m_q <= 1'b0;
        vs_s_q <= 1'b0;
        dl_m_q <= 1'b0;
        dl_s_q <= 1'b0;
      end else begin
        vs_m_q <= vs;
        vs_s_q <= vs_m_q;
        dl_m_q <= dwnld;
        dl_s_q <= dl_m_q;
      end
    end
    assign vs_s = vs_s_q;
    assign dl_s = dl_s_q;
  end else begin : g_nosync
    assign vs_s = vs;
    assign dl_s = dwnld;
  end

  logic   vs_fall, dl_fall, dl_acc, mint_sat;
  logic   is_m2;
  logic [1:0] eff_mode;

  assign vs_fall  = vs_p_q & ~vs_s;
  assign dl_fall  = dl_p_q & ~dl_s;
  assign mint_sat = (mint_q == MINT_SAT);
  assign dl_acc   = dl_fall & mint_sat;
  // mode is live only while IDLE; afterwards the value latched there governs
  assign eff_mode = (state_q == IDLE) ? mode : mode_q;
  assign is_m2    = (eff_mode == 2'd2);

  always_comb begin
    frame_d = frame_q;
    if (is_m2 && (dl_acc || dl_s)) frame_d = '0;
    else if (vs_fall)              frame_d = frame_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case (mode)
          2'd0:       state_d = DUMPING;
          2'd1, 2'd2: state_d = ARMED;
          default:    state_d = IDLE;
        endcase
      end
      ARMED: begin
        if (mode_q == 2'd1 && vs_fall && frame_q == start_frame) state_d = DUMPING;
        if (mode_q == 2'd2 && dl_acc)                            state_d = DUMPING;
      end
      DUMPING: begin
        if (stop_frame != '0 && vs_fall && frame_q == stop_frame) state_d = DONE;
      end
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    dump_on_d  = (state_d == DUMPING) && (state_q != DUMPING);
    dump_off_d = (state_d == DONE) && (state_q != DONE);
    dump_en_d  = (state_q == DUMPING) ? ch_mask : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      frame_q    <= '0;
      dump_en_q  <= '0;
      dump_on_q  <= 1'b0;
      dump_off_q <= 1'b0;
      mint_q     <= '0;
      vs_p_q     <= 1'b0;
      dl_p_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (state_q == IDLE) mode_q <= mode;
      frame_q    <= frame_d;
      dump_en_q  <= dump_en_d;
      dump_on_q  <= dump_on_d;
      dump_off_q <= dump_off_d;
      if (!mint_sat) mint_q <= mint_q + 1'b1;
      vs_p_q     <= vs_s;
      dl_p_q     <= dl_s;
    end
  end

  assign frame_cnt = frame_q;
  assign dump_en   = dump_en_q;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;
  assign st        = state_q;

endmodule

// File: tb/tb_dump_trigger_ctrl.sv
// Directed bench for dump_trigger_ctrl with a queue-based scoreboard; two
// instances cover the synchronised/32-bit and the unsynchronised/4-bit builds.
module tb_dump_trigger_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: CW=32, SYNC=1, MINT=100
  logic        rst_na, vsa, dla;
  logic [1:0]  modea;
  logic [31:0] starta, stopa;
  logic [3:0]  maska;
  logic [31:0] frame_a;
  logic [3:0]  en_a;
  logic        on_a, off_a;
  logic [1:0]  st_a;

  // instance B: CW=4, SYNC=0, MINT=16
  logic        rst_nb, vsb, dlb;
  logic [1:0]  modeb;
  logic [3:0]  startb, stopb;
  logic [3:0]  maskb;
  logic [3:0]  frame_b;
  logic [3:0]  en_b;
  logic        on_b, off_b;
  logic [1:0]  st_b;

  dump_trigger_ctrl #(.CW(32), .CH(4), .SYNC(1), .MINT(100)) u_a (
    .clk(clk), .rst_n(rst_na), .vs(vsa), .dwnld(dla), .mode(modea),
    .start_frame(starta), .stop_frame(stopa), .ch_mask(maska),
    .frame_cnt(frame_a), .dump_en(en_a), .dump_on(on_a), .dump_off(off_a), .st(st_a)
  );

  dump_trigger_ctrl #(.CW(4), .CH(4), .SYNC(0), .MINT(16)) u_b (
    .clk(clk), .rst_n(rst_nb), .vs(vsb), .dwnld(dlb), .mode(modeb),
    .start_frame(startb), .stop_frame(stopb), .ch_mask(maskb),
    .frame_cnt(frame_b), .dump_en(en_b), .dump_on(on_b), .dump_off(off_b), .st(st_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    vsa = 1'b1; tick();
    vsa = 1'b0; tick(); tick(); tick();
  endtask

  task automatic pulse_b();
    vsb = 1'b1; tick();
    vsb = 1'b0; tick();
  endtask

  initial begin
    logic [1:0] exp_st;
    rst_na = 1'b0; vsa = 1'b0; dla = 1'b0; modea = 2'd0;
    starta = '0; stopa = '0; maska = 4'b1010;
    rst_nb = 1'b0; vsb = 1'b0; dlb = 1'b0; modeb = 2'd1;
    startb = 4'd5; stopb = 4'd8; maskb = 4'b0011;
    tick(); tick();

    // reset state
    expect_v("rst_st", 32'd0);      check({30'd0, st_a});
    expect_v("rst_en", 32'd0);      check({28'd0, en_a});
    expect_v("rst_frame", 32'd0);   check(frame_a);
    expect_v("rst_on", 32'd0);      check({31'd0, on_a});

    // mode 0, immediate dump
    rst_na = 1'b1;
    tick();
    expect_v("m0_st", 32'd2);       check({30'd0, st_a});
    expect_v("m0_on", 32'd1);       check({31'd0, on_a});
    expect_v("m0_en_early", 32'd0); check({28'd0, en_a});
    tick();
    expect_v("m0_on_clr", 32'd0);   check({31'd0, on_a});
    expect_v("m0_en", 32'hA);       check({28'd0, en_a});
    modea = 2'd3;
    tick();
    expect_v("m0_mode_ignored", 32'd2); check({30'd0, st_a});
    vsa = 1'b1; tick();
    vsa = 1'b0; tick(); tick();
    expect_v("m0_frame_lat", 32'd0); check(frame_a);
    tick();
    expect_v("m0_frame_inc", 32'd1); check(frame_a);
    maska = 4'b0101;
    tick();
    expect_v("m0_mask_chg", 32'h5);  check({28'd0, en_a});

    // asynchronous reset mid-dump
    rst_na = 1'b0;
    #1;
    expect_v("arst_en", 32'd0);     check({28'd0, en_a});
    expect_v("arst_st", 32'd0);     check({30'd0, st_a});
    @(posedge clk); #1;
    modea = 2'd0;
    rst_na = 1'b1;
    expect_v("arst_no_off", 32'd0); check({31'd0, off_a});
    tick();
    expect_v("arst_restart_st", 32'd2); check({30'd0, st_a});
    expect_v("arst_frame0", 32'd0);     check(frame_a);

    // mode 2, start after download
    rst_na = 1'b0; modea = 2'd2; dla = 1'b1;
    tick();
    rst_na = 1'b1;
    tick();
    expect_v("m2_armed", 32'd1);    check({30'd0, st_a});
    pulse_a(); pulse_a(); pulse_a();
    expect_v("m2_hold_dl", 32'd0);  check(frame_a);
    repeat (30) tick();
    dla = 1'b0;
    repeat (4) tick();
    expect_v("m2_early_dl_ignored", 32'd1); check({30'd0, st_a});
    pulse_a();
    expect_v("m2_count_dl_low", 32'd1);     check(frame_a);
    dla = 1'b1;
    repeat (3) tick();
    expect_v("m2_hold_clear", 32'd0);       check(frame_a);
    repeat (240) tick();
    dla = 1'b0;
    tick(); tick();
    expect_v("m2_sync_lat", 32'd1);  check({30'd0, st_a});
    tick();
    expect_v("m2_dump_st", 32'd2);   check({30'd0, st_a});
    expect_v("m2_dump_on", 32'd1);   check({31'd0, on_a});
    expect_v("m2_frame0", 32'd0);    check(frame_a);
    pulse_a();
    expect_v("m2_frame_after", 32'd1); check(frame_a);
    expect_v("m2_no_stop", 32'd2);     check({30'd0, st_a});

    // mode 1, start 5 stop 8, unsynchronised inputs
    rst_nb = 1'b1;
    tick();
    expect_v("m1_armed", 32'd1);    check({30'd0, st_b});
    for (int i = 1; i <= 10; i++) begin
      pulse_b();
      exp_st = (i < 6) ? 2'd1 : (i < 9) ? 2'd2 : 2'd3;
      expect_v($sformatf("m1_st_%0d", i), {30'd0, exp_st}); check({30'd0, st_b});
      expect_v($sformatf("m1_frame_%0d", i), i);           check({28'd0, frame_b});
      if (i == 6) begin
        expect_v("m1_dump_on", 32'd1);  check({31'd0, on_b});
      end
      if (i == 7) begin
        expect_v("m1_en", 32'h3);       check({28'd0, en_b});
      end
      if (i == 9) begin
        expect_v("m1_dump_off", 32'd1); check({31'd0, off_b});
      end
      if (i == 10) begin
        expect_v("m1_off_single", 32'd0); check({31'd0, off_b});
        expect_v("m1_en_done", 32'd0);    check({28'd0, en_b});
      end
    end

    // wrap: start 14, stop 2 on a 4-bit counter
    rst_nb = 1'b0;
    tick();
    startb = 4'd14; stopb = 4'd2;
    rst_nb = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      pulse_b();
      exp_st = (i < 15) ? 2'd1 : (i < 19) ? 2'd2 : 2'd3;
      expect_v($sformatf("wrap_st_%0d", i), {30'd0, exp_st}); check({30'd0, st_b});
      expect_v($sformatf("wrap_frame_%0d", i), i % 16);      check({28'd0, frame_b});
    end

    // mode 3, disabled
    rst_nb = 1'b0;
    tick();
    modeb = 2'd3;
    rst_nb = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      dlb = 1'b1;
      pulse_b();
      dlb = 1'b0;
      tick();
      expect_v($sformatf("m3_st_%0d", i), 32'd0); check({30'd0, st_b});
      expect_v($sformatf("m3_en_%0d", i), 32'd0); check({28'd0, en_b});
    end
    expect_v("m3_frame", 32'd3);    check({28'd0, frame_b});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
